// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: single-outstanding imem reader feeding a
// DEPTH-entry {pc, instruction} FIFO, with flush/redirect squashing.
module fetch_queue_unit #(
  parameter int                 WIDTH    = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   PC_RESET = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             imem_rdata,
  input  logic                         imem_resp,
  output logic                         imem_read,
  output logic [WIDTH-1:0]             imem_address,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         deq,
  output logic                         valid_out,
  output logic [WIDTH-1:0]             ir_out,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_plus2_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [WIDTH-1:0] ir_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_q [DEPTH];
  logic             push;
  logic             pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < DEPTH_C)) begin
          req_addr_d = fetch_pc_q;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = imem_resp ? S_IDLE : S_DROP;
        end else if (imem_resp) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + WIDTH'(2);
          state_d    = S_IDLE;
        end
      end
      // The read cannot be withdrawn; wait it out and throw the data away.
      S_DROP: begin
        if (imem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) fetch_pc_d = redirect_pc;
  end

  assign pop = !flush && deq && (count_q != '0);

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= PC_RESET;
      req_addr_q <= PC_RESET;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (push) begin
        ir_mem_q[tail_q] <= imem_rdata;
        pc_mem_q[tail_q] <= req_addr_q;
      end
    end
  end

  assign imem_read    = (state_q != S_IDLE);
  assign imem_address = req_addr_q;
  assign valid_out    = (count_q != '0);
  // Head fields are stale when empty; consumers qualify with valid_out.
  assign ir_out       = ir_mem_q[head_q];
  assign pc_out       = pc_mem_q[head_q];
  assign pc_plus2_out = pc_mem_q[head_q] + WIDTH'(2);
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int          D   = 4;
  localparam logic [15:0] PCR = 16'h3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        deq;
  logic        valid_out;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2_out;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue_unit #(.WIDTH(16), .DEPTH(D), .PC_RESET(PCR)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .imem_read(imem_read), .imem_address(imem_address), .flush(flush),
    .redirect_pc(redirect_pc), .deq(deq), .valid_out(valid_out), .ir_out(ir_out),
    .pc_out(pc_out), .pc_plus2_out(pc_plus2_out), .count(count)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fetch, m_addr;
  bit          m_read, m_live, launched;
  int          wait_left, lat_min, lat_max, pops;
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch   = PCR;
    m_addr    = PCR;
    m_read    = 0;
    m_live    = 0;
    wait_left = 0;
  endtask

  task automatic check_outputs();
    logic [15:0] e2;
    check_val("imem_read", imem_read, m_read);
    check_val("imem_address", imem_address, m_addr);
    check_val("count", count, mq.size());
    check_val("valid_out", valid_out, mq.size() != 0);
    if (mq.size() != 0) begin
      e2 = mq[0].pc + 16'd2;
      check_val("pc_out", pc_out, mq[0].pc);
      check_val("ir_out", ir_out, mq[0].ir);
      check_val("pc_plus2_out", pc_plus2_out, e2);
    end
  endtask

  // Behaviour of one clock edge expressed on the queue model.
  task automatic model_step(input bit f, input logic [15:0] rp, input bit d,
                            input bit r, input logic [15:0] rd);
    bit nr;
    nr = m_read ? !r : (!f && (mq.size() < D));
    if (!m_read && nr) begin
      m_addr    = m_fetch;
      m_live    = 1;
      launched  = 1;
      wait_left = $urandom_range(lat_max, lat_min);
    end
    if (f) begin
      mq.delete();
      m_fetch = rp;
      if (m_read && !r) m_live = 0;
    end else begin
      if (d && mq.size() != 0) begin
        void'(mq.pop_front());
        pops++;
      end
      if (m_read && r && m_live) begin
        mq.push_back('{pc: m_addr, ir: rd});
        m_fetch = m_fetch + 16'd2;
      end
    end
    m_read = nr;
  endtask

  task automatic cycle(input bit f, input logic [15:0] rp, input bit d,
                       input bit r, input logic [15:0] rd);
    check_outputs();
    flush       = f;
    redirect_pc = rp;
    deq         = d;
    imem_resp   = r;
    imem_rdata  = rd;
    model_step(f, rp, d, r, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic auto_cycle(input int deq_pct, input int flush_pct);
    bit r;
    r = 0;
    if (m_read) begin
      if (wait_left == 0) r = 1;
      else wait_left--;
    end
    cycle($urandom_range(99) < flush_pct, 16'($urandom) & 16'hFFFE,
          $urandom_range(99) < deq_pct, r, 16'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  initial begin
    int maxc, pops0, k;
    logic [15:0] saved;
    rst_n = 1'b1; flush = 0; redirect_pc = 0; deq = 0; imem_resp = 0; imem_rdata = 0;
    pops = 0; launched = 0;
    lat_min = 0; lat_max = 0;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_val("rst_imem_read", imem_read, 0);
    check_val("rst_imem_address", imem_address, 16'h3000);
    check_val("rst_valid", valid_out, 0);
    check_val("rst_ir", ir_out, 0);
    check_val("rst_pc", pc_out, 0);
    check_val("rst_pc_plus2", pc_plus2_out, 16'h0002);
    check_val("rst_count", count, 0);
    model_reset();
    rst_n = 1'b1;

    // Straight-line fill, no consumer
    lat_min = 2; lat_max = 2;
    repeat (30) auto_cycle(0, 0);
    check_val("fill_count", count, 4);
    check_val("fill_pc", pc_out, 16'h3000);
    check_val("fill_pc_plus2", pc_plus2_out, 16'h3002);
    check_val("fill_read_idle", imem_read, 0);
    check_val("fill_valid", valid_out, 1);

    // Stream with the consumer popping every cycle
    lat_min = 1; lat_max = 1;
    repeat (12) auto_cycle(100, 0);
    maxc = 0; pops0 = pops;
    repeat (40) begin
      auto_cycle(100, 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    check_val("stream_max_count_le1", maxc <= 1, 1);
    check_val("stream_progress", (pops - pops0) >= 5, 1);

    // Flush while a read is in flight
    lat_min = 5; lat_max = 5;
    launched = 0; k = 0;
    while (!launched && k < 30) begin auto_cycle(100, 0); k++; end
    check_val("inflight_launch_seen", launched, 1);
    saved = m_addr;
    cycle(1, 16'h4000, 0, 0, 16'($urandom));
    check_val("drop_count0", count, 0);
    check_val("drop_read_held", imem_read, 1);
    check_val("drop_addr_held", imem_address, saved);
    cycle(0, 16'h0, 0, 0, 16'h0);
    cycle(0, 16'h0, 0, 0, 16'h0);
    check_val("drop_addr_still", imem_address, saved);
    cycle(0, 16'h0, 0, 1, 16'hDEAD);
    check_val("drop_no_enqueue", count, 0);
    check_val("drop_read_low", imem_read, 0);
    lat_min = 0; lat_max = 0;
    cycle(0, 16'h0, 0, 0, 16'h0);
    check_val("redirect_addr", imem_address, 16'h4000);
    check_val("redirect_read", imem_read, 1);

    // Flush with simultaneous resp and deq at count 3
    k = 0;
    while (!(mq.size() == 3 && m_read) && k < 40) begin auto_cycle(0, 0); k++; end
    check_val("cnt3_reached", mq.size() == 3 && m_read, 1);
    cycle(1, 16'h5000, 1, 1, 16'($urandom));
    check_val("flush_resp_count", count, 0);
    check_val("flush_resp_valid", valid_out, 0);
    cycle(0, 16'h0, 0, 0, 16'h0);
    check_val("flush_resp_next_addr", imem_address, 16'h5000);

    // Address wrap and pointer wrap
    cycle(1, 16'hFFFE, 0, 0, 16'h0);
    repeat (25) auto_cycle(0, 0);
    check_val("wrap_head_pc", pc_out, 16'hFFFE);
    check_val("wrap_pc_plus2", pc_plus2_out, 16'h0000);
    auto_cycle(100, 0);
    check_val("wrap_second_pc", pc_out, 16'h0000);
    lat_min = 0; lat_max = 2;
    pops0 = pops;
    repeat (120) auto_cycle(50, 0);
    check_val("ptr_wrap_pops", (pops - pops0) >= 3 * D, 1);

    // Random traffic with redirects
    lat_min = 0; lat_max = 3;
    repeat (600) auto_cycle(60, 5);

    // Asynchronous reset in the middle of a read
    k = 0;
    while (!m_read && k < 30) begin auto_cycle(0, 0); k++; end
    check_val("midread_busy", imem_read, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_read_low", imem_read, 0);
    check_val("async_count0", count, 0);
    check_val("async_valid0", valid_out, 0);
    flush = 0; deq = 0; imem_resp = 0;
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    lat_min = 1; lat_max = 1;
    cycle(0, 16'h0, 0, 1, 16'hBEEF);
    check_val("post_rst_read", imem_read, 1);
    check_val("post_rst_addr", imem_address, 16'h3000);
    repeat (20) auto_cycle(40, 0);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction fetch front end for the lc3b pipeline. It prefetches sequential instruction words from the instruction memory into a DEPTH-entry FIFO, where each entry is a {pc, instruction} pair, and hands them to decode through a valid/deq handshake. A flush/redirect empties the queue, restarts fetch at a new PC, and squashes any memory read still in flight. Decoupling imem latency from decode stalls is new in this generation.

Parameters:
WIDTH, 16, instruction/address word width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
PC_RESET, 16'h0000, fetch PC after reset (WIDTH bits)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_rdata  in  WIDTH  instruction memory read data
imem_resp  in  1  memory response; rdata valid this cycle
imem_read  out  1  read request; held high until imem_resp
imem_address  out  WIDTH  read address; stable while imem_read=1
flush  in  1  redirect request (branch/jump resolved)
redirect_pc  in  WIDTH  new fetch PC; sampled when flush=1
deq  in  1  consumer pops head entry this cycle
valid_out  out  1  head entry valid (count != 0)
ir_out  out  WIDTH  head instruction
pc_out  out  WIDTH  address of head instruction
pc_plus2_out  out  WIDTH  pc_out + 2, modulo 2^WIDTH
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fetch_pc=PC_RESET, req_addr=PC_RESET, count=0, head/tail=0, storage cleared. Outputs: imem_read=0, imem_address=PC_RESET, valid_out=0, ir_out=0, pc_out=0, pc_plus2_out=2. Reset mid-request abandons the request; a late imem_resp after reset in IDLE is ignored.
- FSM states:
  - IDLE: imem_read=0. If !flush && count<DEPTH: req_addr<=fetch_pc, go BUSY.
  - BUSY: imem_read=1, imem_address=req_addr.
    - On imem_resp && !flush: push {req_addr, imem_rdata}, fetch_pc<=fetch_pc+2, go IDLE.
    - On flush with resp in the same cycle: data discarded, go IDLE.
    - On flush without resp: go DROP.
  - DROP: imem_read=1, address unchanged (the request cannot be withdrawn). On imem_resp: discard data, go IDLE. A further flush in DROP only updates fetch_pc.
- Only one outstanding read exists at a time, and launch requires count<DEPTH, so a push can never overflow. imem_read is low for at least one cycle between consecutive requests.
- Pop: when deq && count!=0, head advances. deq while empty is ignored. Push and pop in the same cycle leave count unchanged.
- Head outputs are combinational from storage[head]. When count=0, ir_out and pc_out show stale storage and must be qualified by valid_out.
- Flush (synchronous, highest priority over push/pop/launch):
  - next cycle: count=0, head=tail=0, fetch_pc=redirect_pc.
  - valid_out falls the cycle after flush.
  - no launch in the flush cycle.
- Arithmetic: fetch_pc+2 and pc_plus2_out wrap modulo 2^WIDTH (0xFFFE -> 0x0000). Head/tail pointers wrap modulo DEPTH.
- imem_address always equals req_addr, and changes only on an IDLE->BUSY launch.

Test Plan:
- Straight-line fill: reset with PC_RESET=0x3000, memory latency 2, deq=0. Required: entries 0x3000, 0x3002, 0x3004, 0x3006 are fetched; count reaches 4; imem_read then stays 0; valid_out=1, pc_out=0x3000, pc_plus2_out=0x3002.
- Stream: deq=1 every cycle, latency 1. Required: valid_out pulses and pc_out steps by 2 with no skipped or duplicated PC; count never exceeds 1.
- Flush in flight: flush, redirect_pc=0x4000 one cycle after launching 0x3004. Required: state DROP; imem_address holds 0x3004 until resp; resp data is not enqueued; the next request address is 0x4000; count=0 the cycle after flush.
- Flush with simultaneous resp and deq while count=3. Required: nothing pushed or popped; count=0 next cycle; next fetch at redirect_pc.
- Wrap: redirect_pc=0xFFFE. Required: entries at 0xFFFE then 0x0000; pc_plus2_out=0x0000 at the 0xFFFE head; FIFO pointers wrap correctly over 3*DEPTH pushes/pops.
- Reset mid-read: assert rst_n=0 while BUSY. Required: imem_read=0 and count=0 immediately (asynchronously); after release, the first request goes to PC_RESET.
